// File: rtl/crc_engine_param_if.sv
// Beat stream and result bus of the parametrised streaming CRC checker.
interface crc_engine_param_if #(
    parameter int DATA_W = 8,
    parameter int CRC_W  = 8,
    parameter int LEN_W  = 16
);
    logic              i_valid;
    logic              i_last;
    logic [DATA_W-1:0] i_data;
    logic              i_abort;
    logic              o_busy;
    logic              o_done;
    logic              o_match;
    logic [CRC_W-1:0]  o_crc;
    logic [LEN_W-1:0]  o_len;
    logic [15:0]       o_frame_cnt;
    logic [15:0]       o_err_cnt;

    modport master (
        output i_valid, i_last, i_data, i_abort,
        input  o_busy, o_done, o_match, o_crc, o_len, o_frame_cnt, o_err_cnt
    );

    modport slave (
        input  i_valid, i_last, i_data, i_abort,
        output o_busy, o_done, o_match, o_crc, o_len, o_frame_cnt, o_err_cnt
    );
endinterface

// File: rtl/crc_engine_param.sv
// Streaming MSB-first CRC checker: one beat per cycle, residue/match/length at end of frame.
// Optional good/bad frame counters are enabled by defining CRC_STATS_EN.
module crc_engine_param #(
    parameter int               DATA_W  = 8,
    parameter int               CRC_W   = 8,
    parameter logic [CRC_W-1:0] POLY    = 'h07,
    parameter logic [CRC_W-1:0] INIT    = 'h00,
    parameter logic [CRC_W-1:0] RESIDUE = 'h00,
    parameter int               LEN_W   = 16
) (
    input logic              clk,
    input logic              reset,
    crc_engine_param_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        FINISH
    } state_t;

    state_t             state_q, state_d;
    logic [CRC_W-1:0]   crc_q, crc_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [CRC_W-1:0]   crcOut_q, crcOut_d;
    logic               match_q, match_d;
    logic [LEN_W-1:0]   lenOut_q, lenOut_d;

    logic [CRC_W-1:0]   crcBase;
    logic [CRC_W-1:0]   crcFolded;
    logic [LEN_W-1:0]   lenBase;
    logic [LEN_W-1:0]   lenInc;

    function automatic logic [CRC_W-1:0] foldBeat(input logic [CRC_W-1:0] c,
                                                  input logic [DATA_W-1:0] d);
        logic [CRC_W-1:0] r;
        logic             fb;
        r = c;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            fb = r[CRC_W-1] ^ d[i];
            r  = {r[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
        end
        return r;
    endfunction

    // A beat outside ACCUM always starts a fresh frame, which lets FINISH overlap a new first beat.
    always_comb begin
        crcBase   = (state_q == ACCUM) ? crc_q : INIT;
        lenBase   = (state_q == ACCUM) ? len_q : '0;
        crcFolded = foldBeat(crcBase, bus.i_data);
        lenInc    = (&lenBase) ? lenBase : lenBase + LEN_W'(1);
    end

    always_comb begin
        state_d  = state_q;
        crc_d    = crc_q;
        len_d    = len_q;
        crcOut_d = crcOut_q;
        match_d  = match_q;
        lenOut_d = lenOut_q;
        if (bus.i_abort) begin
            state_d = IDLE;
            crc_d   = INIT;
            len_d   = '0;
        end else if (bus.i_valid && bus.i_last) begin
            state_d  = FINISH;
            crc_d    = INIT;
            len_d    = '0;
            crcOut_d = crcFolded;
            match_d  = (crcFolded == RESIDUE);
            lenOut_d = lenInc;
        end else if (bus.i_valid) begin
            state_d = ACCUM;
            crc_d   = crcFolded;
            len_d   = lenInc;
        end else if (state_q == FINISH) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            crc_q    <= INIT;
            len_q    <= '0;
            crcOut_q <= '0;
            match_q  <= 1'b0;
            lenOut_q <= '0;
        end else begin
            state_q  <= state_d;
            crc_q    <= crc_d;
            len_q    <= len_d;
            crcOut_q <= crcOut_d;
            match_q  <= match_d;
            lenOut_q <= lenOut_d;
        end
    end

    assign bus.o_busy  = (state_q == ACCUM);
    assign bus.o_done  = (state_q == FINISH);
    assign bus.o_crc   = crcOut_q;
    assign bus.o_match = match_q;
    assign bus.o_len   = lenOut_q;

`ifdef CRC_STATS_EN
    logic [15:0] frameCnt_q;
    logic [15:0] errCnt_q;

    // Counters sample the result during the done pulse and stick at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frameCnt_q <= '0;
            errCnt_q   <= '0;
        end else if (state_q == FINISH) begin
            if (match_q && !(&frameCnt_q)) begin
                frameCnt_q <= frameCnt_q + 16'd1;
            end else if (!match_q && !(&errCnt_q)) begin
                errCnt_q <= errCnt_q + 16'd1;
            end
        end
    end

    assign bus.o_frame_cnt = frameCnt_q;
    assign bus.o_err_cnt   = errCnt_q;
`else
    assign bus.o_frame_cnt = 16'd0;
    assign bus.o_err_cnt   = 16'd0;
`endif

endmodule

// File: tb/tb_crc_engine_param.sv
// Bench for crc_engine_param: a CRC-8 and a CRC-16 instance driven with identical beat streams
// and checked against a polynomial long-division reference model.
module tb_crc_engine_param;

    typedef byte unsigned msg_t[$];

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    crc_engine_param_if #(.DATA_W(8), .CRC_W(8),  .LEN_W(16)) if8();
    crc_engine_param_if #(.DATA_W(8), .CRC_W(16), .LEN_W(4))  if16();

    crc_engine_param #(
        .DATA_W(8), .CRC_W(8), .POLY(8'h07), .INIT(8'h00), .RESIDUE(8'h00), .LEN_W(16)
    ) dut8 (
        .clk(clk), .reset(reset), .bus(if8.slave)
    );

    crc_engine_param #(
        .DATA_W(8), .CRC_W(16), .POLY(16'h1021), .INIT(16'hFFFF), .RESIDUE(16'h0000), .LEN_W(4)
    ) dut16 (
        .clk(clk), .reset(reset), .bus(if16.slave)
    );

    int testsRun = 0;
    int testsFailed = 0;
    int doneCnt8 = 0;
    int doneCnt16 = 0;
    int expGood8 = 0;
    int expBad8 = 0;
    int expGood16 = 0;
    int expBad16 = 0;
    logic [7:0]  doneCrc8Q[$];
    logic        doneMatch8Q[$];
    logic [15:0] doneCrc16Q[$];

    // Every done pulse is counted and its result logged for the overlapping-frame checks.
    always @(negedge clk) begin
        if (if8.o_done === 1'b1) begin
            doneCnt8++;
            doneCrc8Q.push_back(if8.o_crc);
            doneMatch8Q.push_back(if8.o_match);
        end
        if (if16.o_done === 1'b1) begin
            doneCnt16++;
            doneCrc16Q.push_back(if16.o_crc);
        end
    end

    // Remainder of (M(x)*x^w + INIT(x)*x^n) modulo (x^w + POLY(x)), by long division over a bit list.
    function automatic logic [31:0] refCrc(input msg_t msg, input int w,
                                           input logic [31:0] poly, input logic [31:0] init);
        bit          bits[$];
        int          n;
        logic [31:0] res;
        foreach (msg[i]) begin
            for (int b = 7; b >= 0; b--) bits.push_back(msg[i][b]);
        end
        n = bits.size();
        for (int j = 0; j < w; j++) bits.push_back(1'b0);
        for (int j = 0; j < w; j++) bits[j] = bits[j] ^ init[w-1-j];
        for (int j = 0; j < n; j++) begin
            if (bits[j]) begin
                bits[j] = 1'b0;
                for (int k = 1; k <= w; k++) bits[j+k] = bits[j+k] ^ poly[w-k];
            end
        end
        res = '0;
        for (int k = 0; k < w; k++) res[w-1-k] = bits[n+k];
        return res;
    endfunction

    function automatic logic [7:0] ref8(input msg_t msg);
        logic [31:0] r;
        r = refCrc(msg, 8, 32'h07, 32'h00);
        return r[7:0];
    endfunction

    function automatic logic [15:0] ref16(input msg_t msg);
        logic [31:0] r;
        r = refCrc(msg, 16, 32'h1021, 32'hFFFF);
        return r[15:0];
    endfunction

    function automatic logic [3:0] len16(input int n);
        return (n > 15) ? 4'd15 : 4'(n);
    endfunction

    task automatic setBeat(input logic v, input logic l, input logic a, input logic [7:0] d);
        if8.i_valid  = v;
        if8.i_last   = l;
        if8.i_abort  = a;
        if8.i_data   = d;
        if16.i_valid = v;
        if16.i_last  = l;
        if16.i_abort = a;
        if16.i_data  = d;
    endtask

    task automatic sendFrame(input msg_t msg);
        for (int i = 0; i < msg.size(); i++) begin
            setBeat(1'b1, (i == msg.size() - 1), 1'b0, msg[i]);
            @(posedge clk);
            #1;
        end
        setBeat(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic tallyExpected(input msg_t msg);
        if (ref8(msg) == 8'h00) expGood8++; else expBad8++;
        if (ref16(msg) == 16'h0000) expGood16++; else expBad16++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        setBeat(1'b0, 1'b0, 1'b0, 8'h00);
        repeat (2) @(negedge clk);
        testsRun++;
        if (if8.o_busy !== 1'b0 || if8.o_done !== 1'b0 || if8.o_match !== 1'b0 ||
            if8.o_crc !== 8'h00 || if8.o_len !== 16'd0 ||
            if8.o_frame_cnt !== 16'd0 || if8.o_err_cnt !== 16'd0) begin
            testsFailed++;
            $display("[TB] FAIL reset8: busy=%0b done=%0b match=%0b crc=%h len=%0d fc=%0d ec=%0d, expected all zero",
                     if8.o_busy, if8.o_done, if8.o_match, if8.o_crc, if8.o_len, if8.o_frame_cnt, if8.o_err_cnt);
        end
        testsRun++;
        if (if16.o_busy !== 1'b0 || if16.o_done !== 1'b0 || if16.o_match !== 1'b0 ||
            if16.o_crc !== 16'h0000 || if16.o_len !== 4'd0) begin
            testsFailed++;
            $display("[TB] FAIL reset16: busy=%0b done=%0b match=%0b crc=%h len=%0d, expected all zero",
                     if16.o_busy, if16.o_done, if16.o_match, if16.o_crc, if16.o_len);
        end
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_known_vectors();
        msg_t        frames[3];
        logic [7:0]  e8;
        logic [15:0] e16;
        int          n;
        frames[0] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        frames[1] = frames[0];
        frames[1].push_back(8'hF4);
        frames[2] = frames[0];
        frames[2].push_back(8'h29);
        frames[2].push_back(8'hB1);
        for (int k = 0; k < 3; k++) begin
            sendFrame(frames[k]);
            @(negedge clk);
            e8  = ref8(frames[k]);
            e16 = ref16(frames[k]);
            n   = frames[k].size();
            tallyExpected(frames[k]);
            testsRun++;
            if (if8.o_done !== 1'b1 || if8.o_crc !== e8 || if8.o_match !== (e8 == 8'h00) ||
                if8.o_len !== 16'(n)) begin
                testsFailed++;
                $display("[TB] FAIL known8[%0d]: done=%0b crc=%h match=%0b len=%0d, expected done=1 crc=%h match=%0b len=%0d",
                         k, if8.o_done, if8.o_crc, if8.o_match, if8.o_len, e8, (e8 == 8'h00), n);
            end
            testsRun++;
            if (if16.o_done !== 1'b1 || if16.o_crc !== e16 || if16.o_match !== (e16 == 16'h0000) ||
                if16.o_len !== len16(n)) begin
                testsFailed++;
                $display("[TB] FAIL known16[%0d]: done=%0b crc=%h match=%0b len=%0d, expected done=1 crc=%h match=%0b len=%0d",
                         k, if16.o_done, if16.o_crc, if16.o_match, if16.o_len, e16, (e16 == 16'h0000), len16(n));
            end
            testsRun++;
            case (k)
                0: if (if8.o_crc !== 8'hF4 || if8.o_match !== 1'b0 || if8.o_len !== 16'd9 ||
                       if16.o_crc !== 16'h29B1) begin
                       testsFailed++;
                       $display("[TB] FAIL check_123456789: crc8=%h match=%0b len=%0d crc16=%h, expected F4 0 9 29b1",
                                if8.o_crc, if8.o_match, if8.o_len, if16.o_crc);
                   end
                1: if (if8.o_crc !== 8'h00 || if8.o_match !== 1'b1 || if8.o_len !== 16'd10) begin
                       testsFailed++;
                       $display("[TB] FAIL check_crc8_good: crc=%h match=%0b len=%0d, expected 00 1 10",
                                if8.o_crc, if8.o_match, if8.o_len);
                   end
                default: if (if16.o_crc !== 16'h0000 || if16.o_match !== 1'b1 || if16.o_len !== 4'd11) begin
                       testsFailed++;
                       $display("[TB] FAIL check_crc16_good: crc=%h match=%0b len=%0d, expected 0000 1 11",
                                if16.o_crc, if16.o_match, if16.o_len);
                   end
            endcase
            if (k == 0) begin
                @(negedge clk);
                testsRun++;
                if (if8.o_done !== 1'b0 || if8.o_crc !== 8'hF4 || if8.o_len !== 16'd9) begin
                    testsFailed++;
                    $display("[TB] FAIL hold_after_done: done=%0b crc=%h len=%0d, expected done=0 crc=f4 len=9",
                             if8.o_done, if8.o_crc, if8.o_len);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        msg_t fa;
        msg_t fb;
        int   c8;
        int   c16;
        fa = '{8'h01, 8'h08};
        fb = '{8'h01, 8'h07};
        repeat (2) @(negedge clk);
        doneCrc8Q.delete();
        doneMatch8Q.delete();
        doneCrc16Q.delete();
        c8  = doneCnt8;
        c16 = doneCnt16;
        sendFrame(fa);
        sendFrame(fb);
        tallyExpected(fa);
        tallyExpected(fb);
        repeat (3) @(negedge clk);
        testsRun++;
        if (doneCnt8 - c8 != 2 || doneCnt16 - c16 != 2) begin
            testsFailed++;
            $display("[TB] FAIL b2b_pulses: dut8=%0d dut16=%0d, expected 2 each", doneCnt8 - c8, doneCnt16 - c16);
        end
        testsRun++;
        if (doneCrc8Q.size() != 2 || doneCrc8Q[0] !== 8'h2D || doneMatch8Q[0] !== 1'b0 ||
            doneCrc8Q[1] !== 8'h00 || doneMatch8Q[1] !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL b2b_crc8: n=%0d crc0=%h m0=%0b crc1=%h m1=%0b, expected 2d 0 00 1",
                     doneCrc8Q.size(), doneCrc8Q[0], doneMatch8Q[0], doneCrc8Q[1], doneMatch8Q[1]);
        end
        testsRun++;
        if (doneCrc16Q.size() != 2 || doneCrc16Q[0] !== ref16(fa) || doneCrc16Q[1] !== ref16(fb)) begin
            testsFailed++;
            $display("[TB] FAIL b2b_crc16: n=%0d crc0=%h crc1=%h, expected %h %h",
                     doneCrc16Q.size(), doneCrc16Q[0], doneCrc16Q[1], ref16(fa), ref16(fb));
        end
    endtask

    task automatic test_abort();
        msg_t f1;
        msg_t fz;
        int   c8;
        int   c16;
        f1 = '{8'h31};
        fz = '{8'h00};
        sendFrame(f1);
        tallyExpected(f1);
        repeat (2) @(negedge clk);
        c8  = doneCnt8;
        c16 = doneCnt16;
        for (int i = 0; i < 3; i++) begin
            setBeat(1'b1, 1'b0, 1'b0, 8'($urandom_range(0, 255)));
            @(posedge clk);
            #1;
        end
        setBeat(1'b1, 1'b1, 1'b1, 8'($urandom_range(0, 255)));
        @(posedge clk);
        #1;
        setBeat(1'b0, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        testsRun++;
        if (if8.o_busy !== 1'b0 || if8.o_crc !== ref8(f1) || if8.o_len !== 16'd1 ||
            if16.o_crc !== ref16(f1)) begin
            testsFailed++;
            $display("[TB] FAIL abort_hold: busy=%0b crc8=%h len=%0d crc16=%h, expected 0 %h 1 %h",
                     if8.o_busy, if8.o_crc, if8.o_len, if16.o_crc, ref8(f1), ref16(f1));
        end
        sendFrame(fz);
        tallyExpected(fz);
        repeat (2) @(negedge clk);
        testsRun++;
        if (doneCnt8 - c8 != 1 || doneCnt16 - c16 != 1) begin
            testsFailed++;
            $display("[TB] FAIL abort_pulses: dut8=%0d dut16=%0d, expected 1 each", doneCnt8 - c8, doneCnt16 - c16);
        end
        testsRun++;
        if (if8.o_crc !== 8'h00 || if8.o_match !== 1'b1 || if8.o_len !== 16'd1 ||
            if16.o_crc !== ref16(fz) || if16.o_len !== 4'd1) begin
            testsFailed++;
            $display("[TB] FAIL abort_next_frame: crc8=%h match=%0b len=%0d crc16=%h len16=%0d, expected 00 1 1 %h 1",
                     if8.o_crc, if8.o_match, if8.o_len, if16.o_crc, if16.o_len, ref16(fz));
        end
    endtask

    task automatic test_reset_midframe();
        int c8;
        int c16;
        c8  = doneCnt8;
        c16 = doneCnt16;
        for (int i = 0; i < 3; i++) begin
            setBeat(1'b1, 1'b0, 1'b0, 8'($urandom_range(0, 255)));
            @(posedge clk);
            #1;
        end
        setBeat(1'b0, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        testsRun++;
        if (if8.o_busy !== 1'b1 || if16.o_busy !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL busy_midframe: busy8=%0b busy16=%0b, expected 1 1", if8.o_busy, if16.o_busy);
        end
        #1 reset = 1'b1;
        #1;
        testsRun++;
        if (if8.o_busy !== 1'b0 || if8.o_done !== 1'b0 || if8.o_match !== 1'b0 || if8.o_crc !== 8'h00 ||
            if8.o_len !== 16'd0 || if16.o_busy !== 1'b0 || if16.o_crc !== 16'h0000 || if16.o_len !== 4'd0 ||
            if8.o_frame_cnt !== 16'd0 || if8.o_err_cnt !== 16'd0) begin
            testsFailed++;
            $display("[TB] FAIL reset_midframe: busy=%0b match=%0b crc8=%h len=%0d crc16=%h len16=%0d fc=%0d ec=%0d, expected all zero",
                     if8.o_busy, if8.o_match, if8.o_crc, if8.o_len, if16.o_crc, if16.o_len, if8.o_frame_cnt, if8.o_err_cnt);
        end
        #1 reset = 1'b0;
        expGood8  = 0;
        expBad8   = 0;
        expGood16 = 0;
        expBad16  = 0;
        repeat (3) @(negedge clk);
        testsRun++;
        if (doneCnt8 != c8 || doneCnt16 != c16 || if8.o_busy !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_no_done: pulses8=%0d pulses16=%0d busy=%0b, expected 0 0 0",
                     doneCnt8 - c8, doneCnt16 - c16, if8.o_busy);
        end
    endtask

    task automatic test_len_saturation();
        msg_t        m;
        logic [7:0]  e8;
        logic [15:0] e16;
        for (int i = 0; i < 20; i++) m.push_back(8'($urandom_range(0, 255)));
        sendFrame(m);
        tallyExpected(m);
        @(negedge clk);
        e8  = ref8(m);
        e16 = ref16(m);
        testsRun++;
        if (if8.o_done !== 1'b1 || if8.o_len !== 16'd20 || if8.o_crc !== e8) begin
            testsFailed++;
            $display("[TB] FAIL len_20_crc8: done=%0b len=%0d crc=%h, expected 1 20 %h", if8.o_done, if8.o_len, if8.o_crc, e8);
        end
        testsRun++;
        if (if16.o_done !== 1'b1 || if16.o_len !== 4'd15 || if16.o_crc !== e16) begin
            testsFailed++;
            $display("[TB] FAIL len_saturate_crc16: done=%0b len=%0d crc=%h, expected 1 15 %h", if16.o_done, if16.o_len, if16.o_crc, e16);
        end
    endtask

    task automatic test_random();
        msg_t        m;
        logic [7:0]  e8;
        logic [15:0] e16;
        int          n;
        for (int f = 0; f < 25; f++) begin
            m.delete();
            n = $urandom_range(1, 12);
            for (int i = 0; i < n; i++) m.push_back(8'($urandom_range(0, 255)));
            if ($urandom_range(0, 1) == 1) m.push_back(ref8(m));
            n = m.size();
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            sendFrame(m);
            tallyExpected(m);
            @(negedge clk);
            e8  = ref8(m);
            e16 = ref16(m);
            testsRun++;
            if (if8.o_done !== 1'b1 || if8.o_crc !== e8 || if8.o_match !== (e8 == 8'h00) ||
                if8.o_len !== 16'(n) || if16.o_done !== 1'b1 || if16.o_crc !== e16 ||
                if16.o_match !== (e16 == 16'h0000) || if16.o_len !== len16(n)) begin
                testsFailed++;
                $display("[TB] FAIL random[%0d]: crc8=%h m8=%0b len8=%0d crc16=%h m16=%0b len16=%0d, expected %h %0b %0d %h %0b %0d",
                         f, if8.o_crc, if8.o_match, if8.o_len, if16.o_crc, if16.o_match, if16.o_len,
                         e8, (e8 == 8'h00), n, e16, (e16 == 16'h0000), len16(n));
            end
        end
    endtask

    task automatic test_stats();
        repeat (2) @(negedge clk);
`ifdef CRC_STATS_EN
        testsRun++;
        if (if8.o_frame_cnt !== 16'(expGood8) || if8.o_err_cnt !== 16'(expBad8)) begin
            testsFailed++;
            $display("[TB] FAIL stats8: good=%0d bad=%0d, expected %0d %0d", if8.o_frame_cnt, if8.o_err_cnt, expGood8, expBad8);
        end
        testsRun++;
        if (if16.o_frame_cnt !== 16'(expGood16) || if16.o_err_cnt !== 16'(expBad16)) begin
            testsFailed++;
            $display("[TB] FAIL stats16: good=%0d bad=%0d, expected %0d %0d", if16.o_frame_cnt, if16.o_err_cnt, expGood16, expBad16);
        end
        force dut8.errCnt_q = 16'hFFFF;
        @(negedge clk);
        release dut8.errCnt_q;
        sendFrame('{8'h31});
        repeat (3) @(negedge clk);
        testsRun++;
        if (if8.o_err_cnt !== 16'hFFFF || if8.o_frame_cnt !== 16'(expGood8)) begin
            testsFailed++;
            $display("[TB] FAIL stats_saturate: bad=%h good=%0d, expected ffff %0d", if8.o_err_cnt, if8.o_frame_cnt, expGood8);
        end
`else
        testsRun++;
        if (if8.o_frame_cnt !== 16'd0 || if8.o_err_cnt !== 16'd0 ||
            if16.o_frame_cnt !== 16'd0 || if16.o_err_cnt !== 16'd0) begin
            testsFailed++;
            $display("[TB] FAIL stats_disabled: fc8=%0d ec8=%0d fc16=%0d ec16=%0d, expected all zero",
                     if8.o_frame_cnt, if8.o_err_cnt, if16.o_frame_cnt, if16.o_err_cnt);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_known_vectors();
        test_back_to_back();
        test_abort();
        test_reset_midframe();
        test_len_saturation();
        test_random();
        test_stats();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/crc_engine_param.md
Name: crc_engine_param

Overview:
Parametrised streaming CRC checker, the successor to the fixed 8-bit CRC8 checker.
- Accepts one DATA_W-bit beat per cycle and folds it into a CRC_W-bit register using polynomial POLY and seed INIT.
- Reports the residue, a match flag, a done strobe and the frame length at end of frame.
- Sits on the receive datapath after the deserialiser; the frame's trailing beats carry the transmitted CRC, MSB first.

Parameters:
- DATA_W, 8, beat width in bits; legal range 1..64.
- CRC_W, 8, CRC register width in bits; legal range 4..32.
- POLY, 'h07, generator polynomial (implicit x^CRC_W term omitted).
- INIT, 'h00, register seed at start of every frame.
- RESIDUE, 'h00, residue value that signals a good frame.
- LEN_W, 16, width of the beat counter.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous active-high reset.
- i_valid  in  1  beat qualifier.
- i_last  in  1  final beat of frame; qualified by i_valid.
- i_data  in  DATA_W  beat data; bit DATA_W-1 is shifted in first.
- i_abort  in  1  synchronous frame discard.
- o_busy  out  1  frame in progress.
- o_done  out  1  one-cycle end-of-frame strobe.
- o_match  out  1  residue equals RESIDUE; valid while o_done, held after.
- o_crc  out  CRC_W  final residue; valid while o_done, held after.
- o_len  out  LEN_W  beats in the frame, including the last beat; saturates at all-ones.
- o_frame_cnt  out  16  good-frame counter (see Optional Feature).
- o_err_cnt  out  16  bad-frame counter (see Optional Feature).

Behaviour:
Reset values:
- Async reset clears o_busy, o_done, o_match, o_len, o_frame_cnt and o_err_cnt to 0.
- o_crc resets to 0; the internal CRC register and state reset to INIT and IDLE.
- Reset mid-frame discards the partial frame with no o_done.

CRC arithmetic:
- Non-reflected and MSB-first, with no output XOR.
- Per beat, the DATA_W bits are processed serially inside one combinational step: fb = crc[CRC_W-1] ^ d; crc = (crc << 1) ^ (fb ? POLY : 0).
- Throughput is one beat per cycle with no back-pressure.
- The computation is width-independent; no restriction that CRC_W be a multiple of DATA_W.

State machine:
- IDLE: o_busy = 0.
  - i_valid & !i_last: fold the beat into INIT, set len = 1, go to ACCUM.
  - i_valid & i_last (single-beat frame): go to FINISH.
- ACCUM: o_busy = 1; each valid beat folds in and increments len.
  - i_valid & i_last: go to FINISH.
- FINISH: a registered one-cycle pulse, overlapping the next IDLE/ACCUM cycle.
  - o_done = 1.
  - o_crc = folded register including the last beat.
  - o_match = (o_crc == RESIDUE).
  - o_len = final count.
  - The internal register reloads INIT in the same edge that captures o_crc.

Latency and output holding:
- Last beat accepted at edge N gives o_done high for the cycle following edge N.
- o_crc, o_match and o_len hold their values until the next o_done.

Back-to-back frames:
- A valid beat in the cycle right after the last beat starts a new frame from INIT; no bubble is required.
- o_done for the old frame and the first beat of the new frame coexist.

i_abort:
- Takes priority over i_valid in the same cycle.
- Returns to IDLE, reloads INIT, clears len, and raises no o_done.
- Previously held outputs are unchanged.

Length counter:
- len saturates at 2^LEN_W-1 and does not wrap.
- CRC accumulation continues while len is saturated.

Other rules:
- i_last without i_valid is ignored.
- i_data is don't-care when i_valid = 0.

Optional Feature:
Macro CRC_STATS_EN.
- Defined:
  - o_frame_cnt increments on each o_done with o_match = 1.
  - o_err_cnt increments on each o_done with o_match = 0.
  - Both counters are 16-bit and saturate at 16'hFFFF.
  - Aborted frames are counted in neither.
  - Both counters clear only on reset.
- Undefined: both ports are driven constant 0 and no counter flops are synthesised.

Test Plan:
1. CRC_W=8, POLY='h07, INIT=0: beats 0x31..0x39 ("123456789"), last on 0x39 -> o_done one cycle later, o_crc=0xF4, o_match=0, o_len=9.
2. Same configuration, beats 0x31..0x39 then 0xF4 as last -> o_crc=0x00, o_match=1, o_len=10.
3. Same configuration, frame [0x01, 0x08] -> o_crc=0x2D, o_match=0. Then frame [0x01, 0x07] sent back-to-back with no gap -> o_crc=0x00, o_match=1, with exactly two o_done pulses in total.
4. CRC_W=16, POLY='h1021, INIT='hFFFF: "123456789" then 0x29, 0xB1 as last -> o_crc=0x0000, o_match=1, o_len=11. Without the trailing bytes -> o_crc=0x29B1.
5. Abort and reset cases:
   - i_abort asserted after 3 beats, then frame [0x00] with last -> one o_done only, o_crc=0x00, o_len=1.
   - reset pulsed mid-frame -> all outputs 0 and no o_done.
6. CRC_STATS_EN defined, running scenarios 1, 2, 3 and 4 in sequence (5 o_done pulses in total) -> o_frame_cnt=3, o_err_cnt=2. Forcing o_err_cnt to 16'hFFFF and sending a bad frame -> o_err_cnt stays 16'hFFFF.
